conv2_window_gen: RTL and testbench



---
 rtl/conv_stream_pkg.sv | 20 ++
 rtl/conv_line_buffer.sv | 25 ++
 rtl/conv2_window_gen.sv | 179 +++++++++++++++++
 tb/tb_conv2_window_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_stream_pkg.sv
// Shared constants, window packing helper and FSM states for the conv streaming blocks.
package conv_stream_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned CH    = 8;
  localparam int unsigned KTAPS = 9;

  typedef enum logic [1:0] {
    RUN,
    COL_FLUSH,
    ROW_FLUSH
  } win_state_e;

  // LSB of tap k of channel c in the flat window bus.
  function automatic int unsigned tap_lsb(input int unsigned c, input int unsigned k,
                                          input int unsigned dw = DW);
    return (c * KTAPS + k) * dw;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row delay line: the word shifted in DEPTH enables ago appears on dout.
module conv_line_buffer import conv_stream_pkg::*; #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = CH * DW
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv2_window_gen.sv
// Streaming 3x3 "same"-padded window generator feeding the conv2 depthwise stage.
module conv2_window_gen
  import conv_stream_pkg::KTAPS, conv_stream_pkg::tap_lsb, conv_stream_pkg::win_state_e,
         conv_stream_pkg::RUN, conv_stream_pkg::COL_FLUSH, conv_stream_pkg::ROW_FLUSH;
#(
  parameter int unsigned IMG_W  = 16,
  parameter int unsigned IMG_H  = 16,
  parameter int unsigned CH     = 8,
  parameter int unsigned DW     = 16,
  parameter int unsigned STRIDE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CH*DW-1:0]          in_act,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [CH*KTAPS*DW-1:0]    out_window,
  output logic                      frame_done
);

  localparam int unsigned PW     = CH * DW;
  localparam int unsigned WW     = CH * KTAPS * DW;
  localparam int unsigned RW     = $clog2(IMG_H + 1);
  localparam int unsigned CW     = $clog2(IMG_W + 1);
  // Scan position that produces the final emitted window of a frame.
  localparam int unsigned LAST_R = (STRIDE == 2) ? ((IMG_H - 1) / 2) * 2 + 1 : IMG_H;
  localparam int unsigned LAST_C = (STRIDE == 2) ? ((IMG_W - 1) / 2) * 2 + 1 : IMG_W;

  win_state_e      state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            adv_c, lb_en_c, emit_c, last_c;
  logic [PW-1:0]   lb1_out, lb2_out;
  logic [3*PW-1:0] col_cur_c, col_d1_q, col_d2_q;
  logic [3*PW-1:0] col_src [3];
  logic            row_ok_c [3];
  logic            col_ok_c [3];
  logic [WW-1:0]   win_c;

  // State and scan-position register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Next state and scan position.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      RUN: begin
        if (in_valid) begin
          if (col_q == CW'(IMG_W - 1)) begin
            col_d   = CW'(IMG_W);
            state_d = COL_FLUSH;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      COL_FLUSH: begin
        col_d   = '0;
        row_d   = row_q + RW'(1);
        state_d = (row_q == RW'(IMG_H - 1)) ? ROW_FLUSH : RUN;
      end
      ROW_FLUSH: begin
        if (col_q == CW'(IMG_W)) begin
          col_d   = '0;
          row_d   = '0;
          state_d = RUN;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Handshake and advance decode; flush positions advance unconditionally.
  always_comb begin
    in_ready = 1'b0;
    adv_c    = 1'b0;
    lb_en_c  = 1'b0;
    case (state_q)
      RUN: begin
        in_ready = 1'b1;
        adv_c    = in_valid;
        lb_en_c  = in_valid;
      end
      COL_FLUSH: adv_c = 1'b1;
      ROW_FLUSH: begin
        adv_c   = 1'b1;
        lb_en_c = (col_q != CW'(IMG_W));
      end
      default: adv_c = 1'b0;
    endcase
  end

  conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb1 (
    .clk  (clk),
    .en   (lb_en_c),
    .din  (in_act),
    .dout (lb1_out)
  );

  conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb2 (
    .clk  (clk),
    .en   (lb_en_c),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  // Current column holds rows r-2, r-1, r from low to high.
  assign col_cur_c = {in_act, lb1_out, lb2_out};

  always_ff @(posedge clk) begin
    if (adv_c) begin
      col_d1_q <= col_cur_c;
      col_d2_q <= col_d1_q;
    end
  end

  // Out-of-frame taps are masked from the counters, so stale buffer data never leaks.
  always_comb begin
    col_src[0] = col_d2_q;
    col_src[1] = col_d1_q;
    col_src[2] = col_cur_c;
    for (int unsigned k = 0; k < 3; k++) begin
      row_ok_c[k] = (32'(row_q) + k >= 32'd2) && (32'(row_q) + k < IMG_H + 2);
      col_ok_c[k] = (32'(col_q) + k >= 32'd2) && (32'(col_q) + k < IMG_W + 2);
    end
  end

  always_comb begin
    win_c = '0;
    for (int unsigned ky = 0; ky < 3; ky++) begin
      for (int unsigned kx = 0; kx < 3; kx++) begin
        for (int unsigned c = 0; c < CH; c++) begin
          if (row_ok_c[ky] && col_ok_c[kx]) begin
            win_c[tap_lsb(c, ky * 3 + kx, DW) +: DW] = col_src[kx][ky * PW + c * DW +: DW];
          end
        end
      end
    end
  end

  // Position (r,c) centres on (r-1,c-1); stride 2 keeps even centres (odd r and c).
  always_comb begin
    emit_c = adv_c && (row_q != '0) && (col_q != '0);
    if (STRIDE == 2) begin
      emit_c = emit_c && row_q[0] && col_q[0];
    end
    last_c = (row_q == RW'(LAST_R)) && (col_q == CW'(LAST_C));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_window <= '0;
    end else begin
      out_valid  <= emit_c;
      frame_done <= emit_c && last_c;
      if (emit_c) begin
        out_window <= win_c;
      end
    end
  end

endmodule

// File: tb/tb_conv2_window_gen.sv
// Directed bench for conv2_window_gen on a 4x4 frame at stride 1 and stride 2.
module tb_conv2_window_gen;

  localparam int unsigned W   = 4;
  localparam int unsigned H   = 4;
  localparam int unsigned NCH = 8;
  localparam int unsigned DWB = 16;
  localparam int unsigned PWB = NCH * DWB;
  localparam int unsigned WWB = NCH * 9 * DWB;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [PWB-1:0] in_act = '0;
  logic           in_ready, out_valid, frame_done;
  logic           in_ready2, out_valid2, frame_done2;
  logic [WWB-1:0] out_window, out_window2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int spurious = 0;
  bit adv_next = 1'b0;

  logic [WWB-1:0] wq[$];
  logic [WWB-1:0] w2q[$];
  bit             fq[$];
  bit             f2q[$];
  int             acc_cyc[$];

  conv2_window_gen #(.IMG_W(W), .IMG_H(H), .CH(NCH), .DW(DWB), .STRIDE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_act     (in_act),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_window (out_window),
    .frame_done (frame_done)
  );

  conv2_window_gen #(.IMG_W(W), .IMG_H(H), .CH(NCH), .DW(DWB), .STRIDE(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_act     (in_act),
    .in_ready   (in_ready2),
    .out_valid  (out_valid2),
    .out_window (out_window2),
    .frame_done (frame_done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (out_valid) begin
      wq.push_back(out_window);
      fq.push_back(frame_done);
      if (!adv_next) spurious = spurious + 1;
    end
    if (out_valid2) begin
      w2q.push_back(out_window2);
      f2q.push_back(frame_done2);
    end
  end

  // Whether the coming edge advances the scan (accept or flush).
  always @(negedge clk) begin
    #2;
    adv_next = !rst && ((in_valid && in_ready) || !in_ready);
  end

  function automatic logic [PWB-1:0] pix_vec(input int r, input int c);
    logic [PWB-1:0] v;
    for (int ch = 0; ch < NCH; ch++) v[ch*DWB +: DWB] = 16'(256 * ch + 16 * r + c);
    return v;
  endfunction

  function automatic logic [WWB-1:0] exp_window(input int cr, input int cc);
    logic [WWB-1:0] w;
    int y, x;
    w = '0;
    for (int ch = 0; ch < NCH; ch++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++) begin
          y = cr - 1 + ky;
          x = cc - 1 + kx;
          if (y >= 0 && y < int'(H) && x >= 0 && x < int'(W))
            w[(ch * 9 + ky * 3 + kx) * DWB +: DWB] = 16'(256 * ch + 16 * y + x);
        end
    return w;
  endfunction

  function automatic int first_diff(input logic [WWB-1:0] a, input logic [WWB-1:0] b);
    for (int i = 0; i < NCH * 9; i++)
      if (a[i*DWB +: DWB] !== b[i*DWB +: DWB]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq.delete(); w2q.delete(); fq.delete(); f2q.delete(); acc_cyc.delete();
  endtask

  task automatic drive(input int npix, input int idle_pct, input bit ff);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < npix && guard < 2000) begin
      @(negedge clk);
      guard++;
      in_valid = (idle_pct == 0) || ($urandom_range(99) >= idle_pct);
      in_act = ff ? '1 : pix_vec((k % 16) / 4, k % 4);
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        k++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (k !== npix) begin
      bad++;
      $display("FAIL drive_timeout accepted=%0d wanted=%0d", k, npix);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_window !== '0) begin bad++; $display("FAIL rst_out_window word=%0d", first_diff(out_window, '0)); end
    rst = 1'b0;
  endtask

  task automatic test_stride1_frame();
    logic [WWB-1:0] w;
    int d;
    do_reset();
    drive(16, 0, 1'b0);
    repeat (10) @(negedge clk);
    total++; if (wq.size() !== 16) begin bad++; $display("FAIL s1_count got=%0d exp=16", wq.size()); end
    for (int i = 0; i < wq.size() && i < 16; i++) begin
      d = first_diff(wq[i], exp_window(i / 4, i % 4));
      total++; if (d !== -1) begin bad++; $display("FAIL s1_win[%0d] word=%0d got=%h exp=%h", i, d, wq[i][d*DWB +: DWB], exp_window(i / 4, i % 4)[d*DWB +: DWB]); end
    end
    if (wq.size() >= 1) begin
      w = wq[0];
      total++; if (w[(3*9+8)*DWB +: DWB] !== 16'h0311) begin bad++; $display("FAIL s1_first_ch3_tap8 got=%h exp=0311", w[(3*9+8)*DWB +: DWB]); end
      total++; if (w[4*DWB +: DWB] !== 16'h0000) begin bad++; $display("FAIL s1_first_ch0_tap4 got=%h exp=0000", w[4*DWB +: DWB]); end
    end
    if (wq.size() == 16) begin
      w = wq[15];
      total++; if (w[(1*9+8)*DWB +: DWB] !== 16'h0000) begin bad++; $display("FAIL s1_last_ch1_tap8 got=%h exp=0000", w[(1*9+8)*DWB +: DWB]); end
      total++; if (w[(1*9+4)*DWB +: DWB] !== 16'h0133) begin bad++; $display("FAIL s1_last_ch1_tap4 got=%h exp=0133", w[(1*9+4)*DWB +: DWB]); end
    end
  endtask

  task automatic test_ready_pattern();
    int k;
    int nfd;
    bit exp_low;
    do_reset();
    k = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      in_valid = (k < 16);
      in_act = pix_vec(k / 4, k % 4);
      exp_low = (i < 25) && ((i % 5 == 4) || i >= 20);
      total++; if (in_ready !== !exp_low) begin bad++; $display("FAIL ready_cycle[%0d] got=%b exp=%b", i, in_ready, !exp_low); end
      if (in_valid && in_ready) k++;
    end
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    nfd = 0;
    foreach (fq[i]) if (fq[i]) nfd++;
    total++; if (nfd !== 1) begin bad++; $display("FAIL ready_fd_count got=%0d exp=1", nfd); end
    total++; if (fq.size() !== 16 || fq[15] !== 1'b1) begin bad++; $display("FAIL ready_fd_pos size=%0d exp fd on window 16", fq.size()); end
  endtask

  task automatic test_stride2();
    int d;
    int nfd;
    int cr[4] = '{0, 0, 2, 2};
    int cc[4] = '{0, 2, 0, 2};
    logic [WWB-1:0] w;
    do_reset();
    drive(16, 0, 1'b0);
    repeat (10) @(negedge clk);
    total++; if (w2q.size() !== 4) begin bad++; $display("FAIL s2_count got=%0d exp=4", w2q.size()); end
    for (int i = 0; i < w2q.size() && i < 4; i++) begin
      d = first_diff(w2q[i], exp_window(cr[i], cc[i]));
      total++; if (d !== -1) begin bad++; $display("FAIL s2_win[%0d] word=%0d got=%h", i, d, w2q[i][d*DWB +: DWB]); end
    end
    if (w2q.size() == 4) begin
      w = w2q[3];
      total++; if (w[0 +: DWB] !== 16'h0011) begin bad++; $display("FAIL s2_c22_tap0 got=%h exp=0011", w[0 +: DWB]); end
      total++; if (f2q[3] !== 1'b1) begin bad++; $display("FAIL s2_fd_last got=%b exp=1", f2q[3]); end
    end
    nfd = 0;
    foreach (f2q[i]) if (f2q[i]) nfd++;
    total++; if (nfd !== 1) begin bad++; $display("FAIL s2_fd_count got=%0d exp=1", nfd); end
  endtask

  task automatic test_gaps();
    int d;
    do_reset();
    spurious = 0;
    drive(16, 40, 1'b0);
    repeat (10) @(negedge clk);
    total++; if (wq.size() !== 16) begin bad++; $display("FAIL gap_count got=%0d exp=16", wq.size()); end
    for (int i = 0; i < wq.size() && i < 16; i++) begin
      d = first_diff(wq[i], exp_window(i / 4, i % 4));
      total++; if (d !== -1) begin bad++; $display("FAIL gap_win[%0d] word=%0d got=%h", i, d, wq[i][d*DWB +: DWB]); end
    end
    total++; if (spurious !== 0) begin bad++; $display("FAIL gap_idle_pulse got=%0d exp=0", spurious); end
  endtask

  task automatic test_mid_reset();
    int d;
    int nff;
    logic [WWB-1:0] w;
    do_reset();
    drive(7, 0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_out_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    wq.delete(); fq.delete(); w2q.delete(); f2q.delete();
    drive(16, 0, 1'b0);
    repeat (10) @(negedge clk);
    total++; if (wq.size() !== 16) begin bad++; $display("FAIL mrst_count got=%0d exp=16", wq.size()); end
    if (wq.size() >= 1) begin
      d = first_diff(wq[0], exp_window(0, 0));
      total++; if (d !== -1) begin bad++; $display("FAIL mrst_first word=%0d got=%h", d, wq[0][d*DWB +: DWB]); end
    end
    nff = 0;
    foreach (wq[i]) begin
      w = wq[i];
      for (int j = 0; j < int'(NCH) * 9; j++) if (w[j*DWB +: DWB] === 16'hFFFF) nff++;
    end
    total++; if (nff !== 0) begin bad++; $display("FAIL mrst_stale_ffff got=%0d exp=0", nff); end
  endtask

  task automatic test_back_to_back();
    int d;
    int nfd;
    do_reset();
    drive(32, 0, 1'b0);
    repeat (10) @(negedge clk);
    total++; if (acc_cyc.size() !== 32) begin bad++; $display("FAIL b2b_accepts got=%0d exp=32", acc_cyc.size()); end
    if (acc_cyc.size() == 32) begin
      total++; if (acc_cyc[16] - acc_cyc[0] !== 25) begin bad++; $display("FAIL b2b_frame_span got=%0d exp=25", acc_cyc[16] - acc_cyc[0]); end
      total++; if (acc_cyc[16] - acc_cyc[15] !== 7) begin bad++; $display("FAIL b2b_restart_gap got=%0d exp=7", acc_cyc[16] - acc_cyc[15]); end
    end
    total++; if (wq.size() !== 32) begin bad++; $display("FAIL b2b_count got=%0d exp=32", wq.size()); end
    for (int i = 0; i < wq.size() && i < 32; i++) begin
      d = first_diff(wq[i], exp_window((i % 16) / 4, i % 4));
      total++; if (d !== -1) begin bad++; $display("FAIL b2b_win[%0d] word=%0d got=%h", i, d, wq[i][d*DWB +: DWB]); end
    end
    nfd = 0;
    foreach (fq[i]) if (fq[i]) nfd++;
    total++; if (nfd !== 2) begin bad++; $display("FAIL b2b_fd_count got=%0d exp=2", nfd); end
    if (fq.size() == 32) begin
      total++; if (fq[15] !== 1'b1 || fq[31] !== 1'b1) begin bad++; $display("FAIL b2b_fd_pos got=%b%b exp=11", fq[15], fq[31]); end
    end
  endtask

  initial begin
    test_reset();
    test_stride1_frame();
    test_ready_pattern();
    test_stride2();
    test_gaps();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
